// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch handshake FSM driving PC/IF-ID enables, bubbles and ack timeout.
// Optional feature macro FETCH_CTRL_PERF_EN adds stall_cnt_o (flush/stall cycle counter).
module fetch_ctrl #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        PC_sel_i,
  input  logic        imem_ack_i,
  output logic        imem_req_o,
  output logic        pc_en_o,
  output logic        ifid_en_o,
  output logic        ifid_flush_o,
`ifdef FETCH_CTRL_PERF_EN
  output logic        timeout_o,
  output logic [31:0] stall_cnt_o
`else
  output logic        timeout_o
`endif
);

  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    FETCH    = 2'd1,
    WAIT_ACK = 2'd2,
    KILL     = 2'd3
  } state_e;

  // Pulse fires on the WAIT_ACK cycle in which the timer would reach ACK_TIMEOUT.
  localparam logic [4:0] TIMEOUT_M1 = 5'(ACK_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [4:0] timer_q, timer_d;

  // State and timer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= HOLD;
      timer_q <= 5'd0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Next-state and combinational output decode.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    imem_req_o   = 1'b0;
    pc_en_o      = 1'b0;
    ifid_en_o    = 1'b0;
    ifid_flush_o = 1'b0;
    timeout_o    = 1'b0;
    case (state_q)
      HOLD: begin
        ifid_flush_o = 1'b1;
        state_d      = FETCH;
      end
      FETCH, WAIT_ACK: begin
        imem_req_o = PC_sel_i | ~stall_i;
        if (PC_sel_i) begin
          pc_en_o      = 1'b1;
          ifid_en_o    = 1'b1;
          ifid_flush_o = 1'b1;
          // A request still outstanding from WAIT_ACK must have its stale response drained.
          if (imem_ack_i || (state_q == FETCH)) begin
            state_d = FETCH;
          end else begin
            state_d = KILL;
          end
        end else if (stall_i) begin
          state_d = FETCH;
        end else if (imem_ack_i) begin
          pc_en_o   = 1'b1;
          ifid_en_o = 1'b1;
          state_d   = FETCH;
        end else begin
          ifid_en_o    = 1'b1;
          ifid_flush_o = 1'b1;
          if (state_q == FETCH) begin
            state_d = WAIT_ACK;
            timer_d = 5'd0;
          end else if (timer_q == TIMEOUT_M1) begin
            timeout_o = 1'b1;
            state_d   = FETCH;
          end else begin
            state_d = WAIT_ACK;
            if (timer_q != 5'h1F) begin
              timer_d = timer_q + 5'd1;
            end else begin
              timer_d = timer_q;
            end
          end
        end
      end
      KILL: begin
        ifid_en_o    = 1'b1;
        ifid_flush_o = 1'b1;
        if (imem_ack_i) begin
          state_d = FETCH;
        end else begin
          state_d = KILL;
        end
      end
      default: begin
        state_d = HOLD;
      end
    endcase
  end

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] stall_cnt_q;

  // Counts bubble/flush and stall cycles, wrapping naturally at 32 bits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= 32'd0;
    end else if (ifid_flush_o || stall_i) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_q <= stall_cnt_q;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed-vector bench for fetch_ctrl; each step drives inputs on the falling
// edge and checks {imem_req, pc_en, ifid_en, ifid_flush, timeout} against hand-derived values.
module tb_fetch_ctrl;

  logic        clk_i;
  logic        rst_ni;
  logic        stall_i;
  logic        PC_sel_i;
  logic        imem_ack_i;
  logic        imem_req_o;
  logic        pc_en_o;
  logic        ifid_en_o;
  logic        ifid_flush_o;
  logic        timeout_o;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] stall_cnt_o;
  logic [31:0] cnt0;
`endif

  int checks;
  int failures;
  int loads;

  logic [4:0] obs;
  assign obs = {imem_req_o, pc_en_o, ifid_en_o, ifid_flush_o, timeout_o};

  fetch_ctrl #(.ACK_TIMEOUT(16)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .stall_i      (stall_i),
    .PC_sel_i     (PC_sel_i),
    .imem_ack_i   (imem_ack_i),
    .imem_req_o   (imem_req_o),
    .pc_en_o      (pc_en_o),
    .ifid_en_o    (ifid_en_o),
    .ifid_flush_o (ifid_flush_o),
`ifdef FETCH_CTRL_PERF_EN
    .timeout_o    (timeout_o),
    .stall_cnt_o  (stall_cnt_o)
`else
    .timeout_o    (timeout_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input logic [4:0] got, input logic [4:0] exp, input string tag);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got req/pc/en/flush/to=%b expected %b", tag, got, exp);
    end
  endtask

  task automatic step(input logic st, input logic sel, input logic ack,
                      input logic [4:0] exp, input string tag);
    @(negedge clk_i);
    stall_i    = st;
    PC_sel_i   = sel;
    imem_ack_i = ack;
    #1;
    check(obs, exp, tag);
    if (pc_en_o && !ifid_flush_o) loads++;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    loads = 0;
    rst_ni = 1'b0;
    stall_i = 1'b0;
    PC_sel_i = 1'b0;
    imem_ack_i = 1'b0;

    // Reset values
    #12;
    check(obs, 5'b00010, "reset_outputs");
`ifdef FETCH_CTRL_PERF_EN
    checks++;
    assert (stall_cnt_o === 32'd0) else begin
      failures++;
      $error("FAIL reset_cnt: got %0d expected 0", stall_cnt_o);
    end
`endif

    // Release with ack held high: one HOLD cycle, then a PC load every cycle
    @(negedge clk_i);
    imem_ack_i = 1'b1;
    rst_ni = 1'b1;
    #1;
    check(obs, 5'b00010, "hold_after_release");
    loads = 0;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 5'b11100, $sformatf("stream_ack%0d", i));
    checks++;
    assert (loads === 4) else begin
      failures++;
      $error("FAIL stream_loads: got %0d expected 4", loads);
    end

    // Ack delayed by 3 cycles: 3 bubbles then an accept
    step(1'b0, 1'b0, 1'b0, 5'b10110, "delay_bubble0");
    step(1'b0, 1'b0, 1'b0, 5'b10110, "delay_bubble1");
    step(1'b0, 1'b0, 1'b0, 5'b10110, "delay_bubble2");
    step(1'b0, 1'b0, 1'b1, 5'b11100, "delay_accept");

    // Two stall cycles during acks: PC and IF/ID hold, ack dropped
    loads = 0;
    step(1'b0, 1'b0, 1'b1, 5'b11100, "stall_pre");
    step(1'b1, 1'b0, 1'b1, 5'b00000, "stall_c0");
    step(1'b1, 1'b0, 1'b1, 5'b00000, "stall_c1");
    step(1'b0, 1'b0, 1'b1, 5'b11100, "stall_resume");
    checks++;
    assert (loads === 2) else begin
      failures++;
      $error("FAIL stall_loads: got %0d expected 2", loads);
    end

    // Redirect in WAIT_ACK, stale ack two cycles later is drained in KILL
    step(1'b0, 1'b0, 1'b0, 5'b10110, "kill_miss");
    step(1'b0, 1'b1, 1'b0, 5'b11110, "kill_redirect");
    step(1'b0, 1'b1, 1'b0, 5'b00110, "kill_hold_sel_ignored");
    step(1'b0, 1'b0, 1'b1, 5'b00110, "kill_stale_ack");
    step(1'b0, 1'b0, 1'b1, 5'b11100, "kill_next_accept");

    // Redirect overrides stall; redirect with ack in WAIT_ACK; stall drops ack in WAIT_ACK
    step(1'b1, 1'b1, 1'b0, 5'b11110, "sel_over_stall");
    step(1'b0, 1'b0, 1'b1, 5'b11100, "sel_over_stall_next");
    step(1'b0, 1'b0, 1'b0, 5'b10110, "wait_sel_ack_miss");
    step(1'b0, 1'b1, 1'b1, 5'b11110, "wait_sel_ack");
    step(1'b0, 1'b0, 1'b1, 5'b11100, "wait_sel_ack_next");
    step(1'b0, 1'b0, 1'b0, 5'b10110, "wait_stall_miss");
    step(1'b1, 1'b0, 1'b1, 5'b00000, "wait_stall_drop");
    step(1'b0, 1'b0, 1'b1, 5'b11100, "wait_stall_refetch");

    // Timeout: bubble in FETCH, 15 quiet WAIT_ACK cycles, pulse on the 16th
    step(1'b0, 1'b0, 1'b0, 5'b10110, "to_miss");
`ifdef FETCH_CTRL_PERF_EN
    cnt0 = stall_cnt_o;
`endif
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b0, 5'b10110, $sformatf("to_wait%0d", i));
    step(1'b0, 1'b0, 1'b0, 5'b10111, "to_pulse");
`ifdef FETCH_CTRL_PERF_EN
    checks++;
    assert ((stall_cnt_o - cnt0) === 32'd16) else begin
      failures++;
      $error("FAIL to_cnt: got %0d expected 16", stall_cnt_o - cnt0);
    end
`endif
    step(1'b0, 1'b0, 1'b1, 5'b11100, "to_reissue");

    // Asynchronous reset while in KILL; ack after release is ignored in HOLD
    step(1'b0, 1'b0, 1'b0, 5'b10110, "rst_miss");
    step(1'b0, 1'b1, 1'b0, 5'b11110, "rst_redirect");
    @(negedge clk_i);
    imem_ack_i = 1'b1;
    PC_sel_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    check(obs, 5'b00010, "rst_async");
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check(obs, 5'b00010, "rst_hold_ignores_ack");
    step(1'b0, 1'b0, 1'b1, 5'b11100, "rst_first_fetch");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
